// File: rtl/cg_pkg.sv
// cg_pkg: shared widths, beat type, server FSM states and log2 helper for the CG vector stream server.
package cg_pkg;
  localparam int element_width = 64;
  localparam int no_of_units = 8;
  localparam int memories_address_width = 32;
  localparam int BEAT_W = element_width * no_of_units;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_GAP} state_t;
  function automatic int log2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int LOG_NU = log2(no_of_units);
endpackage

// File: rtl/cg_vec_bank.sv
// cg_vec_bank: DEPTH x beat RAM, one synchronous write port and two read ports (stream and prev).
module cg_vec_bank
  import cg_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  beat_t                    wd,
  input  logic [$clog2(DEPTH)-1:0] ra,
  input  logic [$clog2(DEPTH)-1:0] pa,
  output beat_t                    rq,
  output beat_t                    pq
);
  beat_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rq = mem[ra];
  assign pq = mem[pa];
endmodule

// File: rtl/cg_vector_stream_server.sv
// cg_vector_stream_server: ping-pong vector banks serving ALU stream reads, prev reads and write-back beats.
// Optional overrun detection (sticky err) is built when CG_VSTREAM_OVERRUN_CHK_EN is defined.
module cg_vector_stream_server
  import cg_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int RD_GAP = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [memories_address_width-1:0] total,
  input  logic                              rd_req,
  output logic                              rd_ready,
  output beat_t                             rd_data,
  output logic                              rd_valid,
  output logic                              rd_done,
  input  logic [memories_address_width-1:0] prev_addr,
  output beat_t                             prev_data,
  input  logic                              wr_we,
  input  beat_t                             wr_data,
  output logic                              wr_done,
  input  logic                              swap,
  output logic                              bank_sel,
  output logic                              err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] GAP_LD = 3'(RD_GAP > 1 ? RD_GAP - 1 : 0);
  state_t state;
  logic [CW-1:0] beats, beats_nxt, rd_cnt, wr_cnt;
  logic [2:0] gap_cnt;
  logic [memories_address_width-1:0] beats_raw;
  logic [AW-1:0] prev_idx;
  logic over, acc, wr_acc, rd_last, wr_last;
  beat_t qa_r, qb_r, qa_p, qb_p;
  assign beats_raw = total >> LOG_NU;
  assign over = beats_raw > memories_address_width'(DEPTH);
  assign beats_nxt = over ? CW'(DEPTH) : (beats_raw == '0 ? CW'(1) : beats_raw[CW-1:0]);
  assign acc = rd_ready & rd_req & ~swap;
  assign wr_acc = wr_we & (state != S_IDLE);
  assign rd_last = rd_cnt == beats - CW'(1);
  assign wr_last = wr_cnt == beats - CW'(1);
  assign prev_idx = AW'(prev_addr % memories_address_width'(DEPTH));
  cg_vec_bank #(.DEPTH(DEPTH)) u_bank_a (
    .clk(clk), .we(wr_acc & bank_sel), .wa(wr_cnt[AW-1:0]), .wd(wr_data),
    .ra(rd_cnt[AW-1:0]), .pa(prev_idx), .rq(qa_r), .pq(qa_p)
  );
  cg_vec_bank #(.DEPTH(DEPTH)) u_bank_b (
    .clk(clk), .we(wr_acc & ~bank_sel), .wa(wr_cnt[AW-1:0]), .wd(wr_data),
    .ra(rd_cnt[AW-1:0]), .pa(prev_idx), .rq(qb_r), .pq(qb_p)
  );
  // A write in the swap cycle still lands in the old write bank: bank enables use pre-swap bank_sel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      bank_sel <= 1'b0;
      rd_ready <= 1'b0;
      rd_valid <= 1'b0;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      rd_data <= '0;
      prev_data <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      beats <= CW'(1);
      gap_cnt <= '0;
    end else begin
      rd_valid <= acc;
      rd_done <= acc & rd_last;
      wr_done <= wr_acc & wr_last;
      prev_data <= bank_sel ? qb_p : qa_p;
      if (acc) rd_data <= bank_sel ? qb_r : qa_r;
      if (swap) begin
        bank_sel <= ~bank_sel;
        rd_cnt <= '0;
        wr_cnt <= '0;
        beats <= beats_nxt;
        state <= S_GAP;
        rd_ready <= 1'b0;
        gap_cnt <= GAP_LD;
      end else begin
        if (acc) rd_cnt <= rd_last ? '0 : rd_cnt + CW'(1);
        if (wr_acc) wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
        if (state == S_IDLE) begin
          state <= S_SERVE;
          rd_ready <= 1'b1;
          beats <= beats_nxt;
        end else if (state == S_SERVE) begin
          if (acc && RD_GAP > 0) begin
            state <= S_GAP;
            rd_ready <= 1'b0;
            gap_cnt <= GAP_LD;
          end
        end else if (gap_cnt == 3'd0) begin
          state <= S_SERVE;
          rd_ready <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt - 3'd1;
        end
      end
    end
  end
`ifdef CG_VSTREAM_OVERRUN_CHK_EN
  logic wr_full;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_full <= 1'b0;
      err <= 1'b0;
    end else begin
      wr_full <= swap ? 1'b0 : (wr_full | (wr_acc & wr_last));
      if ((rd_req & ~rd_ready) | (wr_acc & wr_full) | ((swap | (state == S_IDLE)) & over)) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cg_vector_stream_server.sv
// tb_cg_vector_stream_server: directed stimulus with a bank/queue-level model compared every cycle.
module tb_cg_vector_stream_server;
  import cg_pkg::*;
  localparam int DEPTH = 128;
  localparam int RD_GAP = 1;
`ifdef CG_VSTREAM_OVERRUN_CHK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] total = 32'd32, prev_addr = '0;
  logic rd_req = 1'b0, wr_we = 1'b0, swap = 1'b0;
  beat_t wr_data = '0;
  logic rd_ready, rd_valid, rd_done, wr_done, bank_sel, err;
  beat_t rd_data, prev_data;
  int checks = 0, errors = 0;

  cg_vector_stream_server #(.DEPTH(DEPTH), .RD_GAP(RD_GAP)) dut (
    .clk(clk), .reset(reset), .total(total), .rd_req(rd_req), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done), .prev_addr(prev_addr),
    .prev_data(prev_data), .wr_we(wr_we), .wr_data(wr_data), .wr_done(wr_done),
    .swap(swap), .bank_sel(bank_sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [BEAT_W-1:0] act, input logic [BEAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: two arrays of beats, a read/write position per vector, and a count of not-ready cycles.
  beat_t m_mem [2][DEPTH];
  bit m_known [2][DEPTH];
  int m_sel = 0, m_rd = 0, m_wr = 0, m_beats = 1, m_low = 0, m_pa = 0;
  bit m_idle = 1, m_full = 0, m_acc, m_wacc;
  bit e_ready = 0, e_valid = 0, e_done = 0, e_wrdone = 0, e_err = 0, e_dknown = 1, e_pknown = 0;
  beat_t e_data = '0, e_prev = '0;

  function automatic int calc_beats(input logic [31:0] t);
    int b = int'(t / no_of_units);
    return b == 0 ? 1 : (b > DEPTH ? DEPTH : b);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_idle = 1; m_sel = 0; m_rd = 0; m_wr = 0; m_low = 0; m_full = 0;
      e_ready = 0; e_valid = 0; e_done = 0; e_wrdone = 0; e_err = 0;
      e_data = '0; e_dknown = 1; e_prev = '0; e_pknown = 1;
    end else begin
      m_acc = e_ready && rd_req && !swap;
      m_wacc = wr_we && !m_idle;
`ifdef CG_VSTREAM_OVERRUN_CHK_EN
      if ((rd_req && !e_ready) || (m_wacc && m_full) || ((swap || m_idle) && (total / no_of_units) > DEPTH)) e_err = 1;
`endif
      m_pa = int'(prev_addr % DEPTH);
      e_prev = m_mem[m_sel][m_pa];
      e_pknown = m_known[m_sel][m_pa];
      e_valid = m_acc;
      e_done = 0;
      if (m_acc) begin
        e_data = m_mem[m_sel][m_rd];
        e_dknown = m_known[m_sel][m_rd];
        e_done = (m_rd == m_beats - 1);
        m_rd = (m_rd + 1) % m_beats;
      end
      e_wrdone = 0;
      if (m_wacc) begin
        m_mem[1 - m_sel][m_wr] = wr_data;
        m_known[1 - m_sel][m_wr] = 1;
        e_wrdone = (m_wr == m_beats - 1);
        if (e_wrdone) m_full = 1;
        m_wr = (m_wr + 1) % m_beats;
      end
      if (swap) begin
        m_sel = 1 - m_sel; m_rd = 0; m_wr = 0; m_full = 0;
        m_beats = calc_beats(total);
        m_low = RD_GAP > 0 ? RD_GAP : 1;
      end else if (m_idle) begin
        m_beats = calc_beats(total);
        m_low = 0;
      end else if (m_acc) m_low = RD_GAP;
      else if (m_low > 0) m_low--;
      e_ready = (m_low == 0);
      m_idle = 0;
    end
  end

  always @(negedge clk) begin
    chk("rd_ready", rd_ready, e_ready);
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_done", rd_done, e_done);
    chk("wr_done", wr_done, e_wrdone);
    chk("bank_sel", bank_sel, m_sel[0]);
    chk("err", err, e_err);
    if ((e_valid || !reset) && e_dknown) chk("rd_data", rd_data, e_data);
    if (e_pknown) chk("prev_data", prev_data, e_prev);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int v);
    wr_we = 1'b1;
    wr_data = beat_t'(v);
    tick();
    wr_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rd_ready && n < 16) begin
      tick();
      n++;
    end
    if (!rd_ready) begin
      checks++;
      errors++;
      $display("FAIL rd_ready_timeout got=0 want=1 at %0t", $time);
    end
  endtask

  task automatic rd(input int v, input bit dn);
    wait_ready();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("lit_rd_valid", rd_valid, 1'b1);
    chk("lit_rd_data", rd_data, beat_t'(v));
    chk("lit_rd_done", rd_done, dn);
    chk("lit_rd_gap", rd_ready, 1'b0);
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("lit_reset_ready", rd_ready, 1'b0);
    chk("lit_reset_sel", bank_sel, 1'b0);
    chk("lit_reset_data", rd_data, '0);
    reset = 1'b1;
    tick();
    chk("lit_serve_ready", rd_ready, 1'b1);
    for (int i = 1; i <= 4; i++) wr(i);
    chk("lit_wr_done", wr_done, 1'b1);
    do_swap();
    chk("lit_swap_sel", bank_sel, 1'b1);
    chk("lit_swap_ready", rd_ready, 1'b0);
    for (int i = 1; i <= 4; i++) rd(i, i == 4);
    fork
      for (int i = 0; i < 4; i++) wr(32'hA + i);
      for (int i = 1; i <= 4; i++) rd(i, i == 4);
    join
    do_swap();
    for (int i = 0; i < 4; i++) rd(32'hA + i, i == 3);
    prev_addr = 32'd2;
    wr(32'h11);
    chk("lit_prev", prev_data, beat_t'(32'hC));
    for (int i = 2; i <= 4; i++) wr(32'h10 + i);
    chk("lit_prev_hold", prev_data, beat_t'(32'hC));
    wait_ready();
    rd_req = 1'b1;
    swap = 1'b1;
    tick();
    rd_req = 1'b0;
    swap = 1'b0;
    chk("lit_rdswap_valid", rd_valid, 1'b0);
    chk("lit_rdswap_sel", bank_sel, 1'b1);
    chk("lit_rdswap_ready", rd_ready, 1'b0);
    rd(32'h11, 1'b0);
    chk("lit_prev_newbank", prev_data, beat_t'(32'h13));
    wait_ready();
    rd_req = 1'b1;
    #2 reset = 1'b0;
    tick();
    rd_req = 1'b0;
    chk("lit_rst_valid", rd_valid, 1'b0);
    chk("lit_rst_sel", bank_sel, 1'b0);
    chk("lit_rst_data", rd_data, '0);
    chk("lit_rst_prev", prev_data, '0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) rd(32'hA + i, i == 3);
    for (int i = 1; i <= 4; i++) wr(32'h20 + i);
    chk("lit_wr_done2", wr_done, 1'b1);
    wr(32'h25);
    tick();
    chk("lit_err", err, EXP_ERR);
    total = 32'd0;
    do_swap();
    rd(32'h25, 1'b1);
    rd(32'h25, 1'b1);
    chk("lit_err_sticky", err, EXP_ERR);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
